// File: rtl/barrel_shifter.sv
// 32-bit registered barrel shifter: logical left / arithmetic right via a
// 5-stage logarithmic mux network, one result per cycle with 1-cycle latency.
module barrel_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        sh_dir,
    input  logic [4:0]  sh_amt,
    input  logic [31:0] d_in,
    input  logic        vld_in,
    output logic [31:0] d_out,
    output logic        vld_out
);

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 5;

    // stg[k] is the operand after the stages selected by sh_amt[k-1:0]
    logic signed [DATA_W-1:0] stg [SHIFT_W+1];
    logic signed [DATA_W-1:0] d_p1;
    logic                     vld_p1;

    assign stg[0] = d_in;

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign stg[k+1] = !sh_amt[k] ? stg[k]
                        : (sh_dir ? (stg[k] >>> SH) : (stg[k] << SH));
    end

    // ---- stage p1: result register; data only loads on accepted operations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_in;
            if (vld_in) begin
                d_p1 <= stg[SHIFT_W];
            end
        end
    end

    assign d_out   = d_p1;
    assign vld_out = vld_p1;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: driver pushes expected results, a
// monitor one edge later pops and compares against the DUT outputs.
module tb_barrel_shifter;

    logic        clk;
    logic        rst;
    logic        sh_dir;
    logic [4:0]  sh_amt;
    logic [31:0] d_in;
    logic        vld_in;
    logic [31:0] d_out;
    logic        vld_out;

    barrel_shifter dut (
        .clk     (clk),
        .rst     (rst),
        .sh_dir  (sh_dir),
        .sh_amt  (sh_amt),
        .d_in    (d_in),
        .vld_in  (vld_in),
        .d_out   (d_out),
        .vld_out (vld_out)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] held;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shifts expressed as multiplication / floor division by 2^amt
    function automatic logic [31:0] ref_shift(input logic dir, input logic [4:0] amt,
                                              input logic [31:0] d);
        longint      p;
        longint      v;
        longint      q;
        logic [63:0] m;
        p = 1;
        for (int i = 0; i < int'(amt); i++) p = p * 2;
        if (!dir) begin
            m = {32'b0, d} * 64'(p);
            return m[31:0];
        end
        v = longint'($signed(d));
        if (v >= 0) q = v / p;
        else        q = -((-v + p - 1) / p);
        return 32'(q);
    endfunction

    task automatic apply_x(input logic v, input logic dir, input logic [4:0] amt,
                           input logic [31:0] d, input logic [31:0] exp_d);
        exp_t e;
        vld_in = v;
        sh_dir = dir;
        sh_amt = amt;
        d_in   = d;
        if (v) held = exp_d;
        e.v = v;
        e.d = held;
        exp_q.push_back(e);
    endtask

    task automatic drive_x(input logic v, input logic dir, input logic [4:0] amt,
                           input logic [31:0] d, input logic [31:0] exp_d);
        @(negedge clk);
        apply_x(v, dir, amt, d, exp_d);
    endtask

    task automatic drive(input logic v, input logic dir, input logic [4:0] amt,
                         input logic [31:0] d);
        drive_x(v, dir, amt, d, ref_shift(dir, amt, d));
    endtask

    // ---- monitor: entry pushed at a negedge is due just after the next posedge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("vld_out", 32'(vld_out), 32'(e.v));
            chk("d_out", d_out, e.d);
        end else begin
            chk("idle_vld_out", 32'(vld_out), 32'd0);
        end
    end

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        vld_in   = 1'b0;
        sh_dir   = 1'b0;
        sh_amt   = '0;
        d_in     = '0;
        held     = '0;
        n_checks = 0;
        n_fail   = 0;

        #1;
        chk("reset_d_out", d_out, 32'h0);
        chk("reset_vld_out", 32'(vld_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sweeps: sign-fill right, zero-fill right, walking one left
        for (int n = 0; n < 32; n++) drive(1'b1, 1'b1, 5'(n), 32'h8000_0000);
        for (int n = 0; n < 32; n++) drive(1'b1, 1'b1, 5'(n), 32'h4000_0000);
        for (int n = 0; n < 32; n++) drive(1'b1, 1'b0, 5'(n), 32'h0000_0001);

        // Back-to-back with hand-computed results, then an idle hold cycle
        drive_x(1'b1, 1'b0, 5'd4,  32'h0000_000F, 32'h0000_00F0);
        drive_x(1'b1, 1'b1, 5'd4,  32'hF000_0000, 32'hFF00_0000);
        drive_x(1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000);
        drive_x(1'b0, 1'b1, 5'd7,  32'h1234_5678, 32'h0);
        drive_x(1'b0, 1'bx, 5'bx,  32'hx,         32'h0);
        drive_x(1'b1, 1'b1, 5'd31, 32'h7FFF_FFFF, 32'h0000_0000);
        drive_x(1'b1, 1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        drive_x(1'b1, 1'b1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Reset mid-stream, asserted between edges
        for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), 5'($urandom), $urandom);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midreset_d_out", d_out, 32'h0);
        chk("midreset_vld_out", 32'(vld_out), 32'd0);
        exp_q.delete();
        held = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apply_x(1'b1, 1'b1, 5'd3, 32'h8000_0010, 32'hF000_0002);

        // Random vectors
        for (int i = 0; i < 10000; i++) begin
            logic v;
            v = ($urandom_range(3) != 0);
            drive(v, 1'($urandom), 5'($urandom), $urandom);
        end
        drive_x(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
